// File: rtl/fsm_5_states.sv
// fsm_5_states: five-state round-robin sequencer with run-time state codes.
// The current state arrives on a (normally y fed straight back), and the
// registered next state leaves on y. State codes c0..c4 and the advance
// conditions i0..i4 are supplied at run time.
module fsm_5_states (
  input  logic       clock,
  input  logic       reset,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  input  logic [2:0] c3,
  input  logic [2:0] c4,
  input  logic       en,
  input  logic [2:0] a,
  output logic [2:0] y
);

  logic [2:0] nxt_d;
  logic [2:0] y_q;

  // Next-state selection: the first state code equal to a decides the result.
  // A matching code with its advance condition low self-loops, and later
  // duplicate codes are never consulted. An unmatched a is passed through
  // unchanged, with no recovery.
  always_comb begin
    nxt_d = a;
    if (a == c0) begin
      if (i0) begin
        nxt_d = c1;
      end else begin
        nxt_d = a;
      end
    end else if (a == c1) begin
      if (i1) begin
        nxt_d = c2;
      end else begin
        nxt_d = a;
      end
    end else if (a == c2) begin
      if (i2) begin
        nxt_d = c3;
      end else begin
        nxt_d = a;
      end
    end else if (a == c3) begin
      if (i3) begin
        nxt_d = c4;
      end else begin
        nxt_d = a;
      end
    end else if (a == c4) begin
      if (i4) begin
        nxt_d = c0;
      end else begin
        nxt_d = a;
      end
    end else begin
      nxt_d = a;
    end
  end

  // State register: reset clears it asynchronously, and en gates each update.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q <= 3'd0;
    end else if (en) begin
      y_q <= nxt_d;
    end else begin
      y_q <= y_q;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fsm_5_states.sv
// Self-checking bench for fsm_5_states: directed scenarios followed by
// randomized traffic, checked against a table-driven reference model.
module tb_fsm_5_states;

  logic       clock;
  logic       reset;
  logic [4:0] i_arr;
  logic [2:0] c_arr [5];
  logic       en;
  logic       loop;
  logic [2:0] a_drv;
  logic [2:0] a_w;
  logic [2:0] y;

  int tests;
  int fails;
  logic [2:0] exp_y;

  assign a_w = loop ? y : a_drv;

  fsm_5_states dut (
    .clock (clock),
    .reset (reset),
    .i0    (i_arr[0]),
    .i1    (i_arr[1]),
    .i2    (i_arr[2]),
    .i3    (i_arr[3]),
    .i4    (i_arr[4]),
    .c0    (c_arr[0]),
    .c1    (c_arr[1]),
    .c2    (c_arr[2]),
    .c3    (c_arr[3]),
    .c4    (c_arr[4]),
    .en    (en),
    .a     (a_w),
    .y     (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: scan the code table for the first entry equal to the
  // current state, then either advance around the ring or hold.
  function automatic logic [2:0] ref_next(input logic [2:0] cur);
    for (int k = 0; k < 5; k++) begin
      if (cur == c_arr[k]) begin
        if (i_arr[k]) return c_arr[(k + 1) % 5];
        return cur;
      end
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [2:0] expv);
    tests++;
    assert (y === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, y, expv);
    end
  endtask

  // Advance one rising edge, updating the model from the pre-edge inputs,
  // and then compare the output shortly after the edge.
  task automatic edge_chk(input string tag);
    logic [2:0] cur;
    logic [2:0] nxt;
    cur = loop ? exp_y : a_drv;
    if (!reset) nxt = 3'd0;
    else if (en) nxt = ref_next(cur);
    else nxt = exp_y;
    @(posedge clock);
    exp_y = nxt;
    #1;
    check(tag, exp_y);
  endtask

  task automatic set_codes(input logic [2:0] k0, input logic [2:0] k1,
                           input logic [2:0] k2, input logic [2:0] k3,
                           input logic [2:0] k4);
    c_arr[0] = k0; c_arr[1] = k1; c_arr[2] = k2; c_arr[3] = k3; c_arr[4] = k4;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_y = 3'd0;
    check("reset_async", 3'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    en    = 1'b1;
    loop  = 1'b1;
    a_drv = 3'd0;
    i_arr = 5'b11111;
    exp_y = 3'd0;
    set_codes(3'd0, 3'd1, 3'd2, 3'd3, 3'd4);

    // Reset state, held across edges while reset is low
    #1;
    reset = 1'b0;
    #1;
    check("reset_value", 3'd0);
    edge_chk("reset_hold0");
    edge_chk("reset_hold1");
    @(negedge clock);
    reset = 1'b1;

    // Loop-back, full ring with period 5
    for (int n = 0; n < 7; n++) edge_chk("ring");
    assert (exp_y == 3'd2) else $error("model ring end %0d", exp_y);

    // Advance condition i2 low stalls at state 2
    do_reset();
    i_arr = 5'b11011;
    edge_chk("stall_1");
    edge_chk("stall_2");
    for (int n = 0; n < 3; n++) edge_chk("stall_hold");
    i_arr = 5'b11111;
    edge_chk("stall_release");
    check("stall_release_3", 3'd3);

    // en low for 3 cycles freezes y at 3
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      edge_chk("en_freeze");
      check("en_freeze_3", 3'd3);
    end
    en = 1'b1;
    edge_chk("en_resume");
    check("en_resume_4", 3'd4);

    // Reset asserted between edges while y = 4
    #2;
    reset = 1'b0;
    #1;
    exp_y = 3'd0;
    check("midrun_reset", 3'd0);
    @(negedge clock);
    reset = 1'b1;
    edge_chk("restart");
    check("restart_1", 3'd1);

    // Open-loop with an arbitrary encoding
    loop = 1'b0;
    set_codes(3'd5, 3'd2, 3'd7, 3'd1, 3'd6);
    a_drv = 3'd5; edge_chk("open_a5");  check("open_a5_c", 3'd2);
    a_drv = 3'd6; edge_chk("open_wrap"); check("open_wrap_c", 3'd5);
    a_drv = 3'd3; edge_chk("open_unmatched"); check("open_unm_c", 3'd3);

    // Duplicate codes c1 = c3 = 2: lowest index wins
    set_codes(3'd5, 3'd2, 3'd7, 3'd2, 3'd6);
    a_drv = 3'd2; i_arr = 5'b11111;
    edge_chk("dup_adv"); check("dup_adv_c", 3'd7);
    i_arr = 5'b11101;
    edge_chk("dup_hold"); check("dup_hold_c", 3'd2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 8) == 0) begin
        for (int k = 0; k < 5; k++) c_arr[k] = 3'($urandom_range(0, 7));
      end
      i_arr = 5'($urandom);
      en    = (($urandom % 5) != 0);
      loop  = (($urandom % 3) != 0);
      a_drv = 3'($urandom);
      if (($urandom % 40) == 0) begin
        do_reset();
      end
      edge_chk("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
